// File: rtl/led_sequencer_ctrl_if.sv
// Command, alert and LED signal bundle of the 4-LED bank controller.
// The command/alert source uses the master side; the controller uses the slave side.
interface led_sequencer_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic       alert_req;
    logic [3:0] alert_pattern;
    logic       alert_ack;
    logic [1:0] mode;
    logic       step_tick;
    logic [3:0] led;

    modport master (
        output cmd_valid, cmd_mode, alert_req, alert_pattern,
        input  cmd_ready, alert_ack, mode, step_tick, led
    );

    modport slave (
        input  cmd_valid, cmd_mode, alert_req, alert_pattern,
        output cmd_ready, alert_ack, mode, step_tick, led
    );
endinterface

// File: rtl/led_sequencer_ctrl.sv
// 4-LED bank sequencer: a step prescaler, display modes (off, chase up/down, blink)
// and a pre-empting alert that freezes the running sequence and later resumes it.
module led_sequencer_ctrl #(
    parameter longint unsigned STEP_DIV    = 64'd12500000,
    parameter int unsigned     ALERT_STEPS = 8
) (
    input logic               clk,
    input logic               rst,
    led_sequencer_ctrl_if.slave bus
);

    localparam int unsigned CNT_W  = $clog2(ALERT_STEPS + 1);
    localparam logic [31:0] C_LAST = 32'(STEP_DIV - 64'd1);
    localparam logic [CNT_W-1:0] C_ALERT_LAST = CNT_W'(ALERT_STEPS - 1);

    typedef enum logic {
        ST_NORMAL,
        ST_ALERT
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [31:0]      r_presc;
    logic [CNT_W-1:0] r_alertCnt;
    logic             r_alertPrev;
    logic [3:0]       r_alertPat;
    logic [3:0]       r_saved;
    logic [3:0]       r_led;
    logic [1:0]       r_mode;
    logic             r_ack;

    logic             w_tick;
    logic             w_edge;
    logic             w_accept;
    logic             w_ready;
    logic             w_enter;
    logic             w_exit;
    logic [3:0]       w_savedNext;
    logic [3:0]       w_ledNext;

    assign w_tick   = (r_presc == C_LAST);
    assign w_edge   = bus.alert_req & ~r_alertPrev;
    assign w_accept = bus.cmd_valid & w_ready;

    assign bus.cmd_ready = w_ready;
    assign bus.alert_ack = r_ack;
    assign bus.mode      = r_mode;
    assign bus.step_tick = w_tick;
    assign bus.led       = r_led;

    // Top FSM state register; reset always lands in NORMAL, aborting any alert.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state: an alert edge leaves NORMAL, the last alert tick returns to it.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_NORMAL: if (w_edge) w_stateNext = ST_ALERT;
            ST_ALERT:  if (w_tick && (r_alertCnt == C_ALERT_LAST)) w_stateNext = ST_NORMAL;
            default:   w_stateNext = ST_NORMAL;
        endcase
    end

    // FSM outputs: commands are only taken in NORMAL; entry/exit strobes steer the datapath.
    always_comb begin
        w_ready = 1'b0;
        w_enter = 1'b0;
        w_exit  = 1'b0;
        case (r_state)
            ST_NORMAL: begin
                w_ready = 1'b1;
                w_enter = w_edge;
            end
            ST_ALERT: begin
                w_exit = w_tick && (r_alertCnt == C_ALERT_LAST);
            end
            default: w_ready = 1'b1;
        endcase
    end

    // Prescaler restarts on every accepted command so a new mode gets a full first step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_accept || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 32'd1;
        end
    end

    // Edge detector history, alert pattern capture and alert tick counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alertPrev <= 1'b0;
            r_alertPat  <= '0;
            r_alertCnt  <= '0;
            r_ack       <= 1'b0;
        end else begin
            r_alertPrev <= bus.alert_req;
            r_ack       <= w_enter;
            if (w_enter) begin
                r_alertPat <= bus.alert_pattern;
                r_alertCnt <= '0;
            end else if ((r_state == ST_ALERT) && w_tick) begin
                r_alertCnt <= r_alertCnt + CNT_W'(1);
            end
        end
    end

    // Saved sequence pattern: an accept loads the start pattern and beats a same-cycle tick;
    // ticks advance it only in NORMAL so an alert leaves it frozen.
    always_comb begin
        w_savedNext = r_saved;
        if (w_accept) begin
            case (bus.cmd_mode)
                2'b00:   w_savedNext = 4'b0000;
                2'b01:   w_savedNext = 4'b0001;
                2'b10:   w_savedNext = 4'b1000;
                default: w_savedNext = 4'b1111;
            endcase
        end else if ((r_state == ST_NORMAL) && w_tick) begin
            case (r_mode)
                2'b00:   w_savedNext = 4'b0000;
                2'b01:   w_savedNext = {r_saved[2:0], r_saved[3]};
                2'b10:   w_savedNext = {r_saved[0], r_saved[3:1]};
                default: w_savedNext = ~r_saved;
            endcase
        end
    end

    // LED source: the alert pattern while an alert is (or is becoming) active, else the sequence.
    always_comb begin
        w_ledNext = w_savedNext;
        if (w_enter) begin
            w_ledNext = bus.alert_pattern;
        end else if ((r_state == ST_ALERT) && !w_exit) begin
            w_ledNext = r_alertPat;
        end
    end

    // Mode, saved pattern and registered LED drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= 2'b00;
            r_saved <= 4'b0000;
            r_led   <= 4'b0000;
        end else begin
            if (w_accept) begin
                r_mode <= bus.cmd_mode;
            end
            r_saved <= w_savedNext;
            r_led   <= w_ledNext;
        end
    end

endmodule

// File: tb/tb_led_sequencer_ctrl.sv
// Directed bench for led_sequencer_ctrl with STEP_DIV=4, ALERT_STEPS=2.
// Expected values are queued with the cycle they are due and checked at the falling edge.
module tb_led_sequencer_ctrl;

    localparam longint unsigned P_DIV   = 64'd4;
    localparam int unsigned     P_STEPS = 2;

    localparam int SIG_LED   = 0;
    localparam int SIG_MODE  = 1;
    localparam int SIG_READY = 2;
    localparam int SIG_ACK   = 3;
    localparam int SIG_TICK  = 4;

    typedef struct {
        int         cyc;
        string      tag;
        int         sig;
        logic [3:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   compCnt = 0;
    int   errCnt = 0;
    exp_t sb[$];

    led_sequencer_ctrl_if bus();

    led_sequencer_ctrl #(
        .STEP_DIV   (P_DIV),
        .ALERT_STEPS(P_STEPS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    function automatic logic [3:0] observe(int sig);
        case (sig)
            SIG_LED:   return bus.led;
            SIG_MODE:  return {2'b00, bus.mode};
            SIG_READY: return {3'b000, bus.cmd_ready};
            SIG_ACK:   return {3'b000, bus.alert_ack};
            default:   return {3'b000, bus.step_tick};
        endcase
    endfunction

    task automatic compareVal(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic expectAt(input int c, input string tag, input int sig, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.sig = sig;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] mode,
                                 input logic req, input logic [3:0] pat);
        bus.cmd_valid     = valid;
        bus.cmd_mode      = mode;
        bus.alert_req     = req;
        bus.alert_pattern = pat;
    endtask

    task automatic checkOutput();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                compareVal(sb[i].tag, observe(sb[i].sig), sb[i].val);
                sb.delete(i);
            end
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
        cyc++;
        checkOutput();
    endtask

    task automatic runTo(input int c);
        while (cyc < c) nextCycle();
    endtask

    task automatic flushLeftover();
        while (sb.size() > 0) begin
            compCnt++;
            errCnt++;
            $display("[TB] FAIL %s never reached (due cycle %0d, now %0d) expected=%b",
                     sb[0].tag, sb[0].cyc, cyc, sb[0].val);
            void'(sb.pop_front());
        end
    endtask

    initial begin
        applyStimulus(1'b0, 2'b00, 1'b0, 4'b0000);
        repeat (2) @(negedge clk);
        compareVal("rst_led",   bus.led, 4'b0000);
        compareVal("rst_mode",  {2'b00, bus.mode}, 4'd0);
        compareVal("rst_ready", {3'b000, bus.cmd_ready}, 4'd1);
        compareVal("rst_ack",   {3'b000, bus.alert_ack}, 4'd0);
        rst = 1'b0;
        cyc = 0;

        // CHASE_UP accepted at cycle 10
        expectAt(5,  "idle_led", SIG_LED, 4'b0000);
        expectAt(11, "up_led11", SIG_LED, 4'b0001);
        expectAt(11, "up_mode",  SIG_MODE, 4'd1);
        expectAt(13, "up_tick13", SIG_TICK, 4'd0);
        expectAt(14, "up_tick14", SIG_TICK, 4'd1);
        expectAt(14, "up_led14", SIG_LED, 4'b0001);
        expectAt(15, "up_led15", SIG_LED, 4'b0010);
        expectAt(15, "up_tick15", SIG_TICK, 4'd0);
        expectAt(18, "up_tick18", SIG_TICK, 4'd1);
        expectAt(19, "up_led19", SIG_LED, 4'b0100);
        expectAt(22, "up_tick22", SIG_TICK, 4'd1);
        expectAt(23, "up_led23", SIG_LED, 4'b1000);
        expectAt(27, "up_wrap27", SIG_LED, 4'b0001);
        runTo(10);
        applyStimulus(1'b1, 2'b01, 1'b0, 4'b0000);
        runTo(11);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'b0000);

        // CHASE_DOWN accepted at cycle 30, coinciding with a tick of the old phase
        expectAt(30, "dn_tick30", SIG_TICK, 4'd1);
        expectAt(31, "dn_led31", SIG_LED, 4'b1000);
        expectAt(31, "dn_mode",  SIG_MODE, 4'd2);
        expectAt(35, "dn_led35", SIG_LED, 4'b0100);
        expectAt(39, "dn_led39", SIG_LED, 4'b0010);
        expectAt(43, "dn_led43", SIG_LED, 4'b0001);
        expectAt(47, "dn_wrap47", SIG_LED, 4'b1000);
        runTo(30);
        applyStimulus(1'b1, 2'b10, 1'b0, 4'b0000);
        runTo(31);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'b0000);

        // BLINK at cycle 50, then OFF accepted mid-step at cycle 61
        expectAt(51, "bl_led51", SIG_LED, 4'b1111);
        expectAt(55, "bl_led55", SIG_LED, 4'b0000);
        expectAt(59, "bl_led59", SIG_LED, 4'b1111);
        expectAt(61, "bl_led61", SIG_LED, 4'b1111);
        expectAt(62, "off_led62", SIG_LED, 4'b0000);
        expectAt(62, "off_mode", SIG_MODE, 4'd0);
        expectAt(62, "off_tick62", SIG_TICK, 4'd0);
        expectAt(65, "off_tick65", SIG_TICK, 4'd1);
        expectAt(66, "off_led66", SIG_LED, 4'b0000);
        expectAt(70, "off_led70", SIG_LED, 4'b0000);
        runTo(50);
        applyStimulus(1'b1, 2'b11, 1'b0, 4'b0000);
        runTo(51);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'b0000);
        runTo(61);
        applyStimulus(1'b1, 2'b00, 1'b0, 4'b0000);
        runTo(62);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'b0000);

        // CHASE_UP at 80, alert 1010 at 86, BLINK command held through the alert
        expectAt(85, "al_pre85", SIG_LED, 4'b0010);
        expectAt(87, "al_led87", SIG_LED, 4'b1010);
        expectAt(87, "al_ack87", SIG_ACK, 4'd1);
        expectAt(87, "al_rdy87", SIG_READY, 4'd0);
        expectAt(88, "al_ack88", SIG_ACK, 4'd0);
        expectAt(90, "al_led90", SIG_LED, 4'b1010);
        expectAt(92, "al_mode92", SIG_MODE, 4'd1);
        expectAt(92, "al_rdy92", SIG_READY, 4'd0);
        expectAt(93, "al_rest93", SIG_LED, 4'b0010);
        expectAt(93, "al_rdy93", SIG_READY, 4'd1);
        expectAt(94, "held_led94", SIG_LED, 4'b1111);
        expectAt(94, "held_mode94", SIG_MODE, 4'd3);
        expectAt(96, "lvl_rdy96", SIG_READY, 4'd1);
        expectAt(96, "lvl_ack96", SIG_ACK, 4'd0);
        expectAt(98, "held_led98", SIG_LED, 4'b0000);
        runTo(80);
        applyStimulus(1'b1, 2'b01, 1'b0, 4'b0000);
        runTo(81);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'b0000);
        runTo(86);
        applyStimulus(1'b0, 2'b00, 1'b1, 4'b1010);
        runTo(88);
        applyStimulus(1'b1, 2'b11, 1'b1, 4'b0101);
        runTo(94);
        applyStimulus(1'b0, 2'b00, 1'b1, 4'b0101);
        runTo(100);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'b0000);

        // BLINK accept and alert edge (0110) together at cycle 110
        expectAt(111, "co_mode111", SIG_MODE, 4'd3);
        expectAt(111, "co_led111", SIG_LED, 4'b0110);
        expectAt(111, "co_ack111", SIG_ACK, 4'd1);
        expectAt(111, "co_rdy111", SIG_READY, 4'd0);
        expectAt(118, "co_led118", SIG_LED, 4'b0110);
        expectAt(119, "co_led119", SIG_LED, 4'b1111);
        expectAt(119, "co_rdy119", SIG_READY, 4'd1);
        expectAt(122, "co_led122", SIG_LED, 4'b1111);
        expectAt(123, "co_led123", SIG_LED, 4'b0000);
        runTo(110);
        applyStimulus(1'b1, 2'b11, 1'b1, 4'b0110);
        runTo(111);
        applyStimulus(1'b0, 2'b00, 1'b1, 4'b0110);
        runTo(112);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'b0000);

        // Alert 1100 at 130, then asynchronous reset mid-alert with alert_req held high
        expectAt(131, "ar_led131", SIG_LED, 4'b1100);
        expectAt(131, "ar_ack131", SIG_ACK, 4'd1);
        runTo(130);
        applyStimulus(1'b0, 2'b00, 1'b1, 4'b1100);
        runTo(132);
        flushLeftover();
        #2 rst = 1'b1;
        #1;
        compareVal("arst_led",   bus.led, 4'b0000);
        compareVal("arst_mode",  {2'b00, bus.mode}, 4'd0);
        compareVal("arst_ready", {3'b000, bus.cmd_ready}, 4'd1);
        compareVal("arst_ack",   {3'b000, bus.alert_ack}, 4'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        compareVal("rel_led0", bus.led, 4'b0000);
        compareVal("rel_rdy0", {3'b000, bus.cmd_ready}, 4'd1);
        expectAt(1, "rel_led1", SIG_LED, 4'b1100);
        expectAt(1, "rel_ack1", SIG_ACK, 4'd1);
        expectAt(1, "rel_rdy1", SIG_READY, 4'd0);
        expectAt(2, "rel_ack2", SIG_ACK, 4'd0);
        expectAt(7, "rel_led7", SIG_LED, 4'b1100);
        expectAt(7, "rel_rdy7", SIG_READY, 4'd0);
        expectAt(8, "rel_led8", SIG_LED, 4'b0000);
        expectAt(8, "rel_rdy8", SIG_READY, 4'd1);
        runTo(10);
        flushLeftover();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, errCnt);
        $finish;
    end

endmodule
